// File: rtl/usb3_ep_pkg.sv
// Shared definitions for the USB 3.0 endpoint buffer ring: endpoint mode
// encodings and the control FSM state type.
package usb3_ep_pkg;

  localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
  localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
  localparam logic [1:0] EP_MODE_BULK      = 2'd2;
  localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } ep_state_e;

endpackage

// File: rtl/usb3_ep_ring_ram.sv
// Simple dual-port buffer storage: one write port, one read port with a
// registered (1-cycle) read, single clock, contents not reset.
module usb3_ep_ring_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] q_r;

  // Write port
  always_ff @(posedge clk) begin
    if (wren) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    q_r <= mem_r[raddr];
  end

  assign q = q_r;

endmodule

// File: rtl/usb3_ep_ring.sv
// N-deep ring of USB 3.0 endpoint buffers with occupancy count, overflow flag,
// isochronous overwrite and flush. Define USB3_EP_RING_STATS_EN for counters.
module usb3_ep_ring
  import usb3_ep_pkg::*;
#(
  parameter  int NBUF      = 4,
  parameter  int BUF_WORDS = 256,
  parameter  int DATA_W    = 32,
  localparam int AW        = $clog2(BUF_WORDS),
  localparam int PW        = $clog2(NBUF),
  localparam int LEN_W     = $clog2(BUF_WORDS * DATA_W / 8) + 1,
  localparam int CW        = PW + 1
) (
  input  logic              local_clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic              flush,
  input  logic [AW-1:0]     buf_in_addr,
  input  logic [DATA_W-1:0] buf_in_data,
  input  logic              buf_in_wren,
  output logic              buf_in_ready,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_commit_ack,
  output logic              buf_in_overflow,
  input  logic [AW-1:0]     buf_out_addr,
  output logic [DATA_W-1:0] buf_out_q,
  output logic [LEN_W-1:0]  buf_out_len,
  output logic              buf_out_hasdata,
  input  logic              buf_out_arm,
  output logic              buf_out_arm_ack,
  output logic [CW-1:0]     buf_out_count
`ifdef USB3_EP_RING_STATS_EN
  ,
  output logic [15:0]       stat_commits,
  output logic [15:0]       stat_arms,
  output logic [15:0]       stat_drops
`endif
);

  localparam logic [CW-1:0]    FULL_CNT = CW'(NBUF);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(BUF_WORDS * DATA_W / 8);

  ep_state_e        state_r, state_s;
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_s;
  logic [LEN_W-1:0] len_r [NBUF];
  logic [LEN_W-1:0] out_len_r, clamp_len_s;
  logic             ovf_r, commit_ack_r, arm_ack_r;
  logic             active_s, isoch_s, full_s, empty_s, ready_s;
  logic             commit_ok_s, arm_ok_s, drop_s, reject_s, rd_adv_s;

  assign isoch_s     = (mode == EP_MODE_ISOCH);
  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == '0);
  assign active_s    = (state_r != ST_FLUSH) && !flush;
  assign clamp_len_s = (buf_in_commit_len > MAX_LEN) ? MAX_LEN : buf_in_commit_len;
  assign rd_adv_s    = arm_ok_s || drop_s;
  assign count_s     = count_r + CW'(commit_ok_s) - CW'(rd_adv_s);

  // Control FSM next state and write-side readiness
  always_comb begin
    state_s = state_r;
    ready_s = 1'b0;
    case (state_r)
      ST_RST: begin
        if (flush) state_s = ST_FLUSH; else state_s = ST_IDLE;
        ready_s = 1'b0;
      end
      ST_IDLE, ST_FLUSH: begin
        if (flush) state_s = ST_FLUSH; else state_s = ST_IDLE;
        ready_s = isoch_s || !full_s;
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b0;
      end
    endcase
  end

  // Commit/arm arbitration: arm frees a slot first when full, commit fills first when empty
  always_comb begin
    commit_ok_s = 1'b0;
    arm_ok_s    = 1'b0;
    drop_s      = 1'b0;
    reject_s    = 1'b0;
    if (active_s) begin
      arm_ok_s = buf_out_arm && (!empty_s || buf_in_commit);
      if (buf_in_commit) begin
        if (!full_s || buf_out_arm) begin
          commit_ok_s = 1'b1;
        end else if (isoch_s) begin
          commit_ok_s = 1'b1;
          drop_s      = 1'b1;
        end else begin
          reject_s = 1'b1;
        end
      end else begin
        commit_ok_s = 1'b0;
      end
    end else begin
      arm_ok_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_RST;
    else          state_r <= state_s;
  end

  // Ring pointers, occupancy, length table, overflow flag and acks
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      ovf_r        <= 1'b0;
      commit_ack_r <= 1'b0;
      arm_ack_r    <= 1'b0;
      for (int i = 0; i < NBUF; i++) len_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      ovf_r        <= 1'b0;
      commit_ack_r <= 1'b0;
      arm_ack_r    <= 1'b0;
    end else begin
      if (commit_ok_s) begin
        len_r[wr_ptr_r] <= clamp_len_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (rd_adv_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      if (drop_s || reject_s) ovf_r <= 1'b1;
      count_r      <= count_s;
      commit_ack_r <= commit_ok_s;
      arm_ack_r    <= arm_ok_s;
    end
  end

  // Length of the buffer currently at the read pointer
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) out_len_r <= '0;
    else          out_len_r <= len_r[rd_ptr_r];
  end

`ifdef USB3_EP_RING_STATS_EN
  logic [15:0] stat_commits_r, stat_arms_r, stat_drops_r;

  // Wrapping event counters, cleared by reset and flush
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_commits_r <= 16'd0;
      stat_arms_r    <= 16'd0;
      stat_drops_r   <= 16'd0;
    end else if (flush) begin
      stat_commits_r <= 16'd0;
      stat_arms_r    <= 16'd0;
      stat_drops_r   <= 16'd0;
    end else begin
      if (commit_ok_s)            stat_commits_r <= stat_commits_r + 16'd1;
      if (arm_ok_s)               stat_arms_r    <= stat_arms_r + 16'd1;
      if (drop_s || reject_s)     stat_drops_r   <= stat_drops_r + 16'd1;
    end
  end

  assign stat_commits = stat_commits_r;
  assign stat_arms    = stat_arms_r;
  assign stat_drops   = stat_drops_r;
`endif

  usb3_ep_ring_ram #(
    .DEPTH  (NBUF * BUF_WORDS),
    .ADDR_W (PW + AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (local_clk),
    .wren  (buf_in_wren),
    .waddr ({wr_ptr_r, buf_in_addr}),
    .wdata (buf_in_data),
    .raddr ({rd_ptr_r, buf_out_addr}),
    .q     (buf_out_q)
  );

  assign buf_in_ready      = ready_s;
  assign buf_in_commit_ack = commit_ack_r;
  assign buf_in_overflow   = ovf_r;
  assign buf_out_len       = out_len_r;
  assign buf_out_hasdata   = !empty_s;
  assign buf_out_arm_ack   = arm_ack_r;
  assign buf_out_count     = count_r;

endmodule

// File: tb/tb_usb3_ep_ring.sv
// Self-checking bench for usb3_ep_ring: directed scenarios plus random traffic
// compared against a queue-free ring model built from the behavioural rules.
module tb_usb3_ep_ring;

  localparam int NBUF = 4, BUF_WORDS = 256, DATA_W = 32;
  localparam int AW = 8, LEN_W = 11, CW = 3, MAXB = 1024;

  logic              local_clk = 1'b0;
  logic              reset_n;
  logic [1:0]        mode;
  logic              flush;
  logic [AW-1:0]     buf_in_addr;
  logic [DATA_W-1:0] buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic              buf_in_overflow;
  logic [AW-1:0]     buf_out_addr;
  logic [DATA_W-1:0] buf_out_q;
  logic [LEN_W-1:0]  buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic [CW-1:0]     buf_out_count;

  always #5 local_clk = ~local_clk;

  usb3_ep_ring #(.NBUF(NBUF), .BUF_WORDS(BUF_WORDS), .DATA_W(DATA_W)) dut (
    .local_clk(local_clk), .reset_n(reset_n), .mode(mode), .flush(flush),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_in_overflow(buf_in_overflow), .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q),
    .buf_out_len(buf_out_len), .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
    .buf_out_arm_ack(buf_out_arm_ack), .buf_out_count(buf_out_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: slot indices, fill level and per-slot lengths
  int  m_wr, m_rd, m_cnt;
  bit  m_ovf, m_blocked, m_in_rst;
  int  m_len [NBUF];
  logic [DATA_W-1:0] m_mem [int];

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_blocked = 0; m_in_rst = 1;
    for (int i = 0; i < NBUF; i++) m_len[i] = 0;
    m_mem.delete();
  endfunction

  function automatic bit exp_ready();
    return !m_in_rst && (mode == 2'd1 || m_cnt < NBUF);
  endfunction

  function automatic void model_step(input bit c, input int clen, input bit a, input bit f,
                                     output bit ca, output bit aa);
    ca = 0; aa = 0;
    if (f) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_blocked = 1;
    end else if (m_blocked) begin
      m_blocked = 0;
    end else begin
      if (a && m_cnt == NBUF) begin
        aa = 1; m_rd = (m_rd + 1) % NBUF; m_cnt--;
      end
      if (c) begin
        if (m_cnt < NBUF || mode == 2'd1) begin
          m_len[m_wr] = (clen > MAXB) ? MAXB : clen;
          m_wr = (m_wr + 1) % NBUF;
          ca = 1;
          if (m_cnt < NBUF) m_cnt++;
          else begin m_rd = (m_rd + 1) % NBUF; m_ovf = 1; end
        end else begin
          m_ovf = 1;
        end
      end
      if (a && !aa && m_cnt > 0) begin
        aa = 1; m_rd = (m_rd + 1) % NBUF; m_cnt--;
      end
    end
    m_in_rst = 0;
  endfunction

  task automatic cycle(input bit c, input int clen, input bit a, input bit f, input bit w,
                       input int waddr, input logic [DATA_W-1:0] wdata, input int raddr);
    bit eca, eaa, chk_q;
    int paddr, elen;
    logic [DATA_W-1:0] eq;
    buf_in_commit = c; buf_in_commit_len = clen[LEN_W-1:0];
    buf_out_arm = a; flush = f; buf_in_wren = w;
    buf_in_addr = waddr[AW-1:0]; buf_in_data = wdata; buf_out_addr = raddr[AW-1:0];
    #1;
    check_val("ready", buf_in_ready, exp_ready());
    paddr = m_rd * BUF_WORDS + raddr;
    chk_q = m_mem.exists(paddr) && !(w && (m_wr * BUF_WORDS + waddr) == paddr);
    eq = chk_q ? m_mem[paddr] : '0;
    elen = m_len[m_rd];
    if (w) m_mem[m_wr * BUF_WORDS + waddr] = wdata;
    model_step(c, clen, a, f, eca, eaa);
    @(posedge local_clk); #1;
    buf_in_commit = 0; buf_out_arm = 0; flush = 0; buf_in_wren = 0;
    check_val("commit_ack", buf_in_commit_ack, eca);
    check_val("arm_ack", buf_out_arm_ack, eaa);
    check_val("count", buf_out_count, m_cnt);
    check_val("hasdata", buf_out_hasdata, m_cnt != 0);
    check_val("overflow", buf_in_overflow, m_ovf);
    check_val("len", buf_out_len, elen);
    if (chk_q) check_val("rdata", buf_out_q, eq);
  endtask

  task automatic idle(input int raddr = 0);
    cycle(0, 0, 0, 0, 0, 0, '0, raddr);
  endtask

  task automatic do_commit(input int clen);
    cycle(1, clen, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic do_flush();
    cycle(0, 0, 0, 1, 0, 0, '0, 0);
    idle();
  endtask

  int lens[4] = '{16, 32, 48, 1024};
  int wa[3]   = '{0, 1, 255};
  int rej_lens[4];

  initial begin
    reset_n = 1'b0; mode = 2'd2; flush = 0; buf_in_addr = '0; buf_in_data = '0;
    buf_in_wren = 0; buf_in_commit = 0; buf_in_commit_len = '0; buf_out_addr = '0;
    buf_out_arm = 0;
    model_reset();
    repeat (3) @(posedge local_clk);
    #1;
    check_val("rst_count", buf_out_count, 0);
    check_val("rst_hasdata", buf_out_hasdata, 0);
    check_val("rst_ovf", buf_in_overflow, 0);
    check_val("rst_cack", buf_in_commit_ack, 0);
    check_val("rst_aack", buf_out_arm_ack, 0);
    check_val("rst_len", buf_out_len, 0);
    @(negedge local_clk); reset_n = 1'b1;
    idle(); idle();
    check_val("idle_ready", buf_in_ready, 1);

    // Bulk ordering
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1, wa[k], DATA_W'(i), 0);
      do_commit(lens[i]);
    end
    check_val("bulk_cnt", buf_out_count, 4);
    check_val("bulk_ready", buf_in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      idle(255);
      check_val("bulk_q", buf_out_q, i);
      check_val("bulk_len", buf_out_len, lens[i]);
      cycle(0, 0, 1, 0, 0, 0, '0, 1);
    end
    check_val("bulk_end_cnt", buf_out_count, 0);

    // Bulk full rejection
    for (int i = 0; i < 4; i++) begin
      rej_lens[i] = $urandom_range(1, 1024);
      do_commit(rej_lens[i]);
    end
    do_commit(77);
    check_val("rej_ack", buf_in_commit_ack, 0);
    check_val("rej_ovf", buf_in_overflow, 1);
    check_val("rej_cnt", buf_out_count, 4);
    idle();
    check_val("rej_len", buf_out_len, rej_lens[0]);
    do_flush();

    // Isochronous overwrite
    mode = 2'd1;
    for (int i = 1; i <= 5; i++) begin
      do_commit(i);
      check_val("iso_ack", buf_in_commit_ack, 1);
    end
    check_val("iso_cnt", buf_out_count, 4);
    check_val("iso_ovf", buf_in_overflow, 1);
    idle();
    check_val("iso_len", buf_out_len, 2);
    do_flush();

    // Simultaneous commit and arm at count 2 and count 4
    mode = 2'd2;
    do_commit(10); do_commit(20);
    cycle(1, 30, 1, 0, 0, 0, '0, 0);
    check_val("sim2_cack", buf_in_commit_ack, 1);
    check_val("sim2_aack", buf_out_arm_ack, 1);
    check_val("sim2_cnt", buf_out_count, 2);
    do_commit(40); do_commit(50);
    cycle(1, 60, 1, 0, 0, 0, '0, 0);
    check_val("sim4_cack", buf_in_commit_ack, 1);
    check_val("sim4_aack", buf_out_arm_ack, 1);
    check_val("sim4_cnt", buf_out_count, 4);
    do_flush();

    // Flush with a same-cycle commit at count 3
    do_commit(5); do_commit(6); do_commit(7);
    cycle(1, 8, 0, 1, 0, 0, '0, 0);
    check_val("fl_cack", buf_in_commit_ack, 0);
    check_val("fl_cnt", buf_out_count, 0);
    check_val("fl_hasdata", buf_out_hasdata, 0);
    check_val("fl_ovf", buf_in_overflow, 0);
    idle();

    // Length clamp
    do_commit(2047);
    idle();
    check_val("clamp_len", buf_out_len, 1024);
    do_flush();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 2047), $urandom_range(0, 9) < 4,
            $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, BUF_WORDS - 1), $urandom, $urandom_range(0, BUF_WORDS - 1));
    end

    // Asynchronous reset in the middle of a commit
    mode = 2'd2;
    do_commit(100); do_commit(200);
    buf_in_commit = 1; buf_in_commit_len = 11'd300;
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_count", buf_out_count, 0);
    check_val("arst_hasdata", buf_out_hasdata, 0);
    check_val("arst_ovf", buf_in_overflow, 0);
    check_val("arst_cack", buf_in_commit_ack, 0);
    check_val("arst_len", buf_out_len, 0);
    buf_in_commit = 0;
    model_reset();
    @(posedge local_clk);
    @(negedge local_clk); reset_n = 1'b1;
    idle(); idle();
    do_commit(64);
    check_val("post_rst_cnt", buf_out_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
